wb_line_memory: RTL and testbench

Wishbone line-granular slave that terminates the L2-side bus driven by the icache/dcache arbiter. It accepts one 128-bit line request at a time (read, or byte-masked write via SEL), models a fixed access latency with a down-counter, and answers with a single-cycle ACK plus read data. Retry is driven while a strobed request is outstanding. It stands in for L2/physical memory in integration runs and serves as the reference responder for arbiter verification.

---
 rtl/wb_line_memory.sv | 196 +++++++++++++++++++
 tb/tb_wb_line_memory.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_line_memory.sv
// ---------------------------------------------------------------------------
// wb_line_memory
//
// Wishbone slave that stands in for L2 / physical memory behind the
// icache/dcache arbiter. It serves one 128-bit line request at a time. A
// request is either a read or a byte-masked write. A fixed access latency is
// modelled with a down-counter. Each completed request returns a single-cycle
// ACK, and read data is registered on DAT_S.
//
// Parameters
//   DEPTH_LINES    number of stored lines (power of two, at least 2); the line
//                  index is the low log2(DEPTH_LINES) bits of ADR, and the
//                  upper ADR bits alias
//   READ_LATENCY   cycles from acceptance to ACK for reads  (1..15)
//   WRITE_LATENCY  cycles from acceptance to ACK for writes (1..15)
//
// Ports
//   CLK     clock, rising edge
//   RST_N   asynchronous active-low reset
//   CYC     bus cycle valid
//   STB     strobe; a request exists only while CYC && STB
//   WE      1 = write, 0 = read
//   ADR     line address (16-byte lines)
//   SEL     byte enables for writes; bit i covers DAT_M[8i+7:8i]
//   DAT_M   write data
//   DAT_S   registered read data; holds until the next completed read
//   ACK     one-cycle completion pulse
//   RTY     combinational: request present and not being acknowledged
// ---------------------------------------------------------------------------
module wb_line_memory #(
    parameter int DEPTH_LINES   = 64,
    parameter int READ_LATENCY  = 3,
    parameter int WRITE_LATENCY = 2
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         CYC,
    input  logic         STB,
    input  logic         WE,
    input  logic [11:0]  ADR,
    input  logic [15:0]  SEL,
    input  logic [127:0] DAT_M,
    output logic [127:0] DAT_S,
    output logic         ACK,
    output logic         RTY
);

    localparam int IDX_W = $clog2(DEPTH_LINES);

    // The counter is loaded with LAT-1. It then counts down to zero in BUSY,
    // and the access happens on the edge that finds it at zero. So ACK
    // appears in the cycle after edge t+LAT, where t is the accept edge.
    localparam logic [3:0] RD_CNT = 4'(READ_LATENCY - 1);
    localparam logic [3:0] WR_CNT = 4'(WRITE_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t             state;
    state_t             next_state;

    logic [3:0]         cnt;
    logic [11:0]        req_adr;
    logic               req_we;
    logic [15:0]        req_sel;
    logic [127:0]       req_dat;

    logic [127:0]       mem [DEPTH_LINES];

    logic               req_valid;
    logic               req_changed;
    logic               latch_req;
    logic               dec_cnt;
    logic               do_access;
    logic [IDX_W-1:0]   req_idx;

    assign req_valid   = CYC && STB;
    // A different master showing up through the arbiter shows up as a new
    // address or direction while STB stays high.
    assign req_changed = (ADR != req_adr) || (WE != req_we);
    assign req_idx     = req_adr[IDX_W-1:0];

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and datapath control
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        next_state = state;
        latch_req  = 1'b0;
        dec_cnt    = 1'b0;
        do_access  = 1'b0;

        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    latch_req  = 1'b1;
                    next_state = BUSY;
                end
            end

            BUSY: begin
                // Withdrawal takes priority over everything, including a
                // counter that has already reached zero.
                if (!req_valid) begin
                    next_state = IDLE;
                end else if (req_changed) begin
                    latch_req = 1'b1;
                end else if (cnt != 4'd0) begin
                    dec_cnt = 1'b1;
                end else begin
                    do_access  = 1'b1;
                    next_state = RESP;
                end
            end

            RESP: begin
                // A strobe still held high here belongs to the request being
                // acknowledged. It is never accepted as a new request.
                next_state = IDLE;
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Request registers, latency counter and read data
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt     <= 4'd0;
            req_adr <= 12'h000;
            req_we  <= 1'b0;
            req_sel <= 16'h0000;
            req_dat <= 128'h0;
            DAT_S   <= 128'h0;
        end else begin
            if (latch_req) begin
                req_adr <= ADR;
                req_we  <= WE;
                req_sel <= SEL;
                req_dat <= DAT_M;
                cnt     <= WE ? WR_CNT : RD_CNT;
            end else if (dec_cnt) begin
                cnt <= cnt - 4'd1;
            end

            if (do_access && !req_we) begin
                DAT_S <= mem[req_idx];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Line storage
    // -----------------------------------------------------------------------
    // NOTE: the array has no reset. Contents survive RST_N, and a line that
    // was never written reads as X. Leaving it out of the reset keeps it
    // mappable onto plain RAM. A write needs do_access, which is only ever
    // set from the BUSY state, so a reset during BUSY cannot leak a write.
    always_ff @(posedge CLK) begin
        if (do_access && req_we) begin
            for (int i = 0; i < 16; i++) begin
                if (req_sel[i]) begin
                    mem[req_idx][8*i +: 8] <= req_dat[8*i +: 8];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // ACK is decoded straight from the state register. That gives no
    // combinational path from the bus inputs to it.
    assign ACK = (state == RESP);
    assign RTY = req_valid && !ACK;

endmodule

// File: tb/tb_wb_line_memory.sv
// ---------------------------------------------------------------------------
// tb_wb_line_memory
//
// Scoreboard bench for wb_line_memory. The driver issues requests. For each
// one it pushes the expected response into a queue: the ACK edge and, for
// reads, the data. This comes from a byte-level memory model. A monitor
// samples the DUT on every falling edge and checks ACK, RTY and DAT_S
// against the head of that queue.
// ---------------------------------------------------------------------------
module tb_wb_line_memory;

    localparam int DEPTH = 64;
    localparam int RL    = 3;
    localparam int WL    = 2;

    logic         clk;
    logic         rst_n;
    logic         cyc;
    logic         stb;
    logic         we;
    logic [11:0]  adr;
    logic [15:0]  sel;
    logic [127:0] dat_m;
    logic [127:0] dat_s;
    logic         ack;
    logic         rty;

    wb_line_memory #(
        .DEPTH_LINES  (DEPTH),
        .READ_LATENCY (RL),
        .WRITE_LATENCY(WL)
    ) dut (
        .CLK  (clk),
        .RST_N(rst_n),
        .CYC  (cyc),
        .STB  (stb),
        .WE   (we),
        .ADR  (adr),
        .SEL  (sel),
        .DAT_M(dat_m),
        .DAT_S(dat_s),
        .ACK  (ack),
        .RTY  (rty)
    );

    typedef struct {
        logic         we;
        logic [127:0] data;
        logic [127:0] mask;
        int           ack_edge;
    } exp_t;

    exp_t         sb[$];
    int           checks   = 0;
    int           errors   = 0;
    int           edge_cnt = 0;

    // Byte-level reference memory. Only bytes that have been written are known.
    logic [7:0]   mdata  [DEPTH][16];
    bit           mknown [DEPTH][16];

    // Last value DAT_S must be holding, and which of its bytes are known.
    logic [127:0] mon_last = 128'h0;
    logic [127:0] mon_mask = {128{1'b1}};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt++;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Apply the request to the reference model and queue its expected response.
    // t is the edge at which the DUT samples the request.
    task automatic push_expect(input logic we_v, input logic [11:0] adr_v, input logic [15:0] sel_v,
                               input logic [127:0] dat_v, input int t);
        int   idx;
        exp_t e;
        idx        = int'(adr_v) % DEPTH;
        e.we       = we_v;
        e.data     = 128'h0;
        e.mask     = 128'h0;
        e.ack_edge = t + (we_v ? WL : RL);
        for (int i = 0; i < 16; i++) begin
            if (we_v) begin
                if (sel_v[i]) begin
                    mdata[idx][i]  = dat_v[8*i +: 8];
                    mknown[idx][i] = 1'b1;
                end
            end else if (mknown[idx][i]) begin
                e.data[8*i +: 8] = mdata[idx][i];
                e.mask[8*i +: 8] = 8'hFF;
            end
        end
        sb.push_back(e);
    endtask

    task automatic drive_req(input logic we_v, input logic [11:0] adr_v, input logic [15:0] sel_v,
                             input logic [127:0] dat_v);
        cyc   = 1'b1;
        stb   = 1'b1;
        we    = we_v;
        adr   = adr_v;
        sel   = sel_v;
        dat_m = dat_v;
    endtask

    task automatic release_bus();
        cyc = 1'b0;
        stb = 1'b0;
    endtask

    // Wait (bounded) for ACK. With hold set, keep STB high through the
    // ACK cycle before releasing the bus.
    task automatic wait_ack(input bit hold);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                ok = 1'b1;
                break;
            end
        end
        check("ack_timeout", 128'(ok), 128'(1));
        if (hold) begin
            @(posedge clk); #1;
        end
        release_bus();
    endtask

    task automatic run_txn(input logic we_v, input logic [11:0] adr_v, input logic [15:0] sel_v,
                           input logic [127:0] dat_v, input bit hold);
        @(posedge clk); #1;
        drive_req(we_v, adr_v, sel_v, dat_v);
        push_expect(we_v, adr_v, sel_v, dat_v, edge_cnt + 1);
        wait_ack(hold);
    endtask

    // Request accepted, then withdrawn one cycle later. No response is expected.
    task automatic abort_txn(input logic we_v, input logic [11:0] adr_v, input logic [127:0] dat_v);
        @(posedge clk); #1;
        drive_req(we_v, adr_v, 16'hFFFF, dat_v);
        @(posedge clk); #1;
        release_bus();
        repeat (3) @(posedge clk);
    endtask

    // A request in BUSY is replaced by one with a different direction and
    // address. Only the second request completes.
    task automatic switch_txn(input logic we1, input logic [11:0] adr1, input logic [11:0] adr2,
                              input logic [15:0] sel2, input logic [127:0] dat2);
        @(posedge clk); #1;
        drive_req(we1, adr1, 16'hFFFF, ~dat2);
        @(posedge clk); #1;
        drive_req(!we1, adr2, sel2, dat2);
        push_expect(!we1, adr2, sel2, dat2, edge_cnt + 1);
        wait_ack(1'b0);
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // -----------------------------------------------------------------------
    // Monitor
    // -----------------------------------------------------------------------
    initial begin
        exp_t e;
        logic exp_ack;
        forever begin
            @(negedge clk);
            exp_ack = (sb.size() > 0) && (sb[0].ack_edge == edge_cnt);
            check("ack", 128'(ack), 128'(exp_ack));
            check("rty", 128'(rty), 128'(cyc && stb && !exp_ack));
            if (exp_ack) begin
                e = sb.pop_front();
                if (!e.we) begin
                    check("rd_data", dat_s & e.mask, e.data & e.mask);
                    mon_last = e.data;
                    mon_mask = e.mask;
                end
            end else begin
                check("dat_s_hold", dat_s & mon_mask, mon_last & mon_mask);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin
        logic [127:0] val_a;
        logic [127:0] val_b;
        logic [127:0] all_ones;
        int           kind;
        logic         rwe;
        logic [11:0]  radr;

        all_ones = {128{1'b1}};
        val_a    = 128'hA5A5_0001_0203_0405_0607_0809_0A0B_0C0D;
        val_b    = 128'h5A5A_FFEE_DDCC_BBAA_9988_7766_5544_3322;

        for (int l = 0; l < DEPTH; l++) begin
            for (int b = 0; b < 16; b++) begin
                mknown[l][b] = 1'b0;
                mdata[l][b]  = 8'h00;
            end
        end

        rst_n = 1'b1;
        cyc   = 1'b0;
        stb   = 1'b0;
        we    = 1'b0;
        adr   = 12'h000;
        sel   = 16'h0000;
        dat_m = 128'h0;
        #1 rst_n = 1'b0;
        #1;
        check("reset_ack", 128'(ack), 128'(0));
        check("reset_rty", 128'(rty), 128'(0));
        check("reset_dat_s", dat_s, 128'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Full write then read at default latencies.
        run_txn(1'b1, 12'h010, 16'hFFFF, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b0);
        run_txn(1'b0, 12'h010, 16'h0000, 128'h0, 1'b0);

        // Reset in the middle of a write: the write must be dropped.
        run_txn(1'b1, 12'h005, 16'hFFFF, val_a, 1'b0);
        run_txn(1'b0, 12'h005, 16'h0000, 128'h0, 1'b0);
        @(posedge clk); #1;
        drive_req(1'b1, 12'h005, 16'hFFFF, val_b);
        @(posedge clk); #1;
        rst_n = 1'b0;
        release_bus();
        sb.delete();
        mon_last = 128'h0;
        mon_mask = all_ones;
        #1;
        check("midbusy_reset_ack", 128'(ack), 128'(0));
        check("midbusy_reset_dat_s", dat_s, 128'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run_txn(1'b0, 12'h005, 16'h0000, 128'h0, 1'b0);

        // Byte mask: bytes 4..7 cleared, the rest stay all-ones.
        run_txn(1'b1, 12'h011, 16'hFFFF, all_ones, 1'b0);
        run_txn(1'b1, 12'h011, 16'h00F0, 128'h0, 1'b0);
        run_txn(1'b0, 12'h011, 16'h0000, 128'h0, 1'b0);

        // SEL = 0 write is acknowledged but changes nothing.
        run_txn(1'b1, 12'h011, 16'h0000, 128'h0, 1'b0);
        run_txn(1'b0, 12'h011, 16'h0000, 128'h0, 1'b0);

        // Withdrawal: no ACK and DAT_S unchanged; next read is accepted normally.
        abort_txn(1'b0, 12'h020, 128'h0);
        run_txn(1'b0, 12'h010, 16'h0000, 128'h0, 1'b0);

        // Request switch from a read of 0x030 to a write of 0x031.
        run_txn(1'b1, 12'h030, 16'hFFFF, val_a, 1'b0);
        run_txn(1'b1, 12'h031, 16'hFFFF, val_b, 1'b0);
        switch_txn(1'b0, 12'h030, 12'h031, 16'hFFFF, 128'hC0FF_EE00_1122_3344_5566_7788_99AA_BBCC);
        run_txn(1'b0, 12'h030, 16'h0000, 128'h0, 1'b0);
        run_txn(1'b0, 12'h031, 16'h0000, 128'h0, 1'b0);

        // Aliasing with STB held through the ACK cycle.
        run_txn(1'b1, 12'h040, 16'hFFFF, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555, 1'b1);
        run_txn(1'b0, 12'h000, 16'h0000, 128'h0, 1'b1);
        run_txn(1'b0, 12'h040, 16'h0000, 128'h0, 1'b0);

        // Randomized traffic over a small aliased set of lines.
        for (int n = 0; n < 90; n++) begin
            kind = int'($urandom_range(0, 9));
            rwe  = 1'($urandom);
            radr = {6'($urandom), 6'($urandom_range(0, 7))};
            repeat ($urandom_range(0, 2)) @(posedge clk);
            if (kind == 0) begin
                abort_txn(rwe, radr, rand128());
            end else if (kind == 1) begin
                switch_txn(rwe, radr, {6'($urandom), 6'($urandom_range(0, 7))},
                           16'($urandom), rand128());
            end else begin
                run_txn(rwe, radr, 16'($urandom), rand128(), 1'($urandom));
            end
        end

        repeat (5) @(posedge clk);
        check("sb_drained", 128'(sb.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
